// File: rtl/rfile_sequencer.sv
// rtl/rfile_sequencer.sv - four-state read/execute/write-back micro-sequencer driving a register file
// Optional flags register block: define RFSEQ_FLAGS_EN to build flag_z/flag_c.
module rfile_sequencer #(
   parameter int BW   = 8,
   parameter int NREG = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   instr,
   input  logic          instr_valid,
   output logic          instr_ready,
   output logic [3:0]    AA,
   output logic [3:0]    BA,
   input  logic [BW-1:0] Adata,
   input  logic [BW-1:0] Bdata,
   output logic [3:0]    DA,
   output logic [BW-1:0] din,
   output logic          RW,
   output logic          done,
   output logic          err,
   output logic          flag_z,
   output logic          flag_c
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_MOV = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_LDI = 4'hA;

   localparam logic [4:0] NREG_L = 5'(NREG);

   logic [1:0]    state;
   logic [15:0]   ir;
   logic [BW-1:0] op_a;
   logic [BW-1:0] op_b;

   logic [3:0]    opc;
   logic [3:0]    dst;
   logic [3:0]    src_a;
   logic [3:0]    src_b;
   logic          legal_op;
   logic          uses_a;
   logic          uses_b;
   logic          uses_dst;
   logic          bad_addr;
   logic          illegal;
   logic          writes;
   logic [BW-1:0] imm_ext;
   logic [BW-1:0] result;

   assign opc   = ir[15:12];
   assign dst   = ir[11:8];
   assign src_a = ir[7:4];
   assign src_b = ir[3:0];

   assign instr_ready = (state == S_IDLE);

   // Only the address fields an opcode actually consumes are range-checked.
   always_comb begin
      legal_op = (opc <= OP_LDI);
      uses_dst = 1'b0;
      uses_a   = 1'b0;
      uses_b   = 1'b0;
      case (opc)
         OP_MOV, OP_NOT, OP_SHL, OP_SHR: begin
            uses_dst = 1'b1;
            uses_a   = 1'b1;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            uses_dst = 1'b1;
            uses_a   = 1'b1;
            uses_b   = 1'b1;
         end
         OP_LDI: uses_dst = 1'b1;
         default: ;
      endcase
      bad_addr = (uses_dst && ({1'b0, dst}   >= NREG_L)) ||
                 (uses_a   && ({1'b0, src_a} >= NREG_L)) ||
                 (uses_b   && ({1'b0, src_b} >= NREG_L));
      illegal  = !legal_op || bad_addr;
      writes   = !illegal && (opc != OP_NOP);
   end

   always_comb begin
      imm_ext      = '0;
      imm_ext[7:0] = ir[7:0];
   end

   always_comb begin
      result = '0;
      case (opc)
         OP_MOV: result = op_a;
         OP_ADD: result = op_a + op_b;
         OP_SUB: result = op_a - op_b;
         OP_AND: result = op_a & op_b;
         OP_OR:  result = op_a | op_b;
         OP_XOR: result = op_a ^ op_b;
         OP_NOT: result = ~op_a;
         OP_SHL: result = {op_a[BW-2:0], 1'b0};
         OP_SHR: result = {1'b0, op_a[BW-1:1]};
         OP_LDI: result = imm_ext;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         ir    <= '0;
         op_a  <= '0;
         op_b  <= '0;
         AA    <= '0;
         BA    <= '0;
         DA    <= '0;
         din   <= '0;
         RW    <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               RW   <= 1'b0;
               done <= 1'b0;
               err  <= 1'b0;
               if (instr_valid) begin
                  ir    <= instr;
                  AA    <= instr[7:4];
                  BA    <= instr[3:0];
                  state <= S_READ;
               end
            end
            S_READ: begin
               op_a  <= Adata;
               op_b  <= Bdata;
               state <= S_EXEC;
            end
            S_EXEC: begin
               // Write-back strobes are registered here so they are live for the whole WB cycle.
               DA    <= dst;
               din   <= result;
               RW    <= writes;
               done  <= 1'b1;
               err   <= illegal;
               state <= S_WB;
            end
            default: begin
               RW    <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef RFSEQ_FLAGS_EN
   logic [BW:0] add_wide;
   logic        carry;

   assign add_wide = {1'b0, op_a} + {1'b0, op_b};

   always_comb begin
      carry = 1'b0;
      case (opc)
         OP_ADD: carry = add_wide[BW];
         OP_SUB: carry = (op_a < op_b);
         OP_SHL: carry = op_a[BW-1];
         OP_SHR: carry = op_a[0];
         default: carry = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else if (state == S_EXEC && writes) begin
         flag_z <= (result == '0);
         flag_c <= carry;
      end
   end
`else
   assign flag_z = 1'b0;
   assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_rfile_sequencer.sv
// tb/tb_rfile_sequencer.sv - directed self-checking bench for rfile_sequencer with a register file model
module tb_rfile_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  AA;
   logic [3:0]  BA;
   logic [7:0]  Adata;
   logic [7:0]  Bdata;
   logic [3:0]  DA;
   logic [7:0]  din;
   logic        RW;
   logic        done;
   logic        err;
   logic        flag_z;
   logic        flag_c;

   int total = 0;
   int bad   = 0;

   logic [7:0] rf [0:8];

   rfile_sequencer #(.BW(8), .NREG(9)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .AA(AA), .BA(BA), .Adata(Adata), .Bdata(Bdata),
      .DA(DA), .din(din), .RW(RW), .done(done), .err(err),
      .flag_z(flag_z), .flag_c(flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (RW && DA < 4'd9) rf[DA] <= din;
   end

   assign Adata = (AA < 4'd9) ? rf[AA] : 8'h00;
   assign Bdata = (BA < 4'd9) ? rf[BA] : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic z, input logic c);
      logic ez, ec;
`ifdef RFSEQ_FLAGS_EN
      ez = z;
      ec = c;
`else
      ez = 1'b0;
      ec = 1'b0;
`endif
      chk({tag, "_z"}, 32'(flag_z), 32'(ez));
      chk({tag, "_c"}, 32'(flag_c), 32'(ec));
   endtask

   // Leaves the bench at the falling edge of the READ cycle.
   task automatic issue(input string tag, input logic [15:0] ins);
      int waited = 0;
      @(negedge clk);
      while (!instr_ready && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, "_ready_idle"}, 32'(instr_ready), 32'd1);
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 16'hFFFF;
      chk({tag, "_ready_read"}, 32'(instr_ready), 32'd0);
   endtask

   task automatic run(input string tag, input logic [15:0] ins, input logic rw,
                      input logic [7:0] exp_din, input logic er, input logic z, input logic c);
      issue(tag, ins);
      @(negedge clk);
      chk({tag, "_ready_exec"}, 32'(instr_ready), 32'd0);
      chk({tag, "_rw_exec"}, 32'(RW), 32'd0);
      @(negedge clk);
      chk({tag, "_ready_wb"}, 32'(instr_ready), 32'd0);
      chk({tag, "_rw"}, 32'(RW), 32'(rw));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_err"}, 32'(err), 32'(er));
      if (rw) begin
         chk({tag, "_da"}, 32'(DA), 32'(ins[11:8]));
         chk({tag, "_din"}, 32'(din), 32'(exp_din));
      end
      chk_flags(tag, z, c);
      @(negedge clk);
      chk({tag, "_rw_after"}, 32'(RW), 32'd0);
      chk({tag, "_done_after"}, 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      instr       = 16'h0000;
      instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_rw", 32'(RW), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_aa", 32'(AA), 32'd0);
      chk("rst_ba", 32'(BA), 32'd0);
      chk("rst_da", 32'(DA), 32'd0);
      chk("rst_din", 32'(din), 32'd0);
      chk_flags("rst", 1'b0, 1'b0);

      run("ldi1",    16'hA15A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      run("ldi_r1",  16'hA1F0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      run("ldi_r2",  16'hA220, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      run("add",     16'h2312, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
      run("sub",     16'h3421, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1);
      run("sub_eq",  16'h3522, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      run("ill_op",  16'hC123, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      run("ill_dst", 16'h2912, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      run("nop",     16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      run("mov",     16'h1019, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      run("ill_src", 16'h1090, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      run("and",     16'h4612, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      run("or",      16'h5712, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      run("xor",     16'h6711, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      run("not",     16'h772F, 1'b1, 8'hDF, 1'b0, 1'b0, 1'b0);
      run("shl",     16'h8810, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b1);
      run("shr0",    16'h9620, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      run("shr1",    16'h9670, 1'b1, 8'h6F, 1'b0, 1'b0, 1'b1);
      run("ldi_z",   16'hA800, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      run("ldi_ff",  16'hA1FF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      run("ldi_ill", 16'hA900, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      run("shl_ff",  16'h8211, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
      chk("rf_r6", 32'(rf[6]), 32'h6F);
      chk("rf_r7", 32'(rf[7]), 32'hDF);

      // Reset lands on the EXEC cycle of an ADD that would overwrite R3.
      issue("rst_mid", 16'h2312);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_ready", 32'(instr_ready), 32'd1);
      chk("rst_mid_rw", 32'(RW), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk_flags("rst_mid", 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_mid_rw2", 32'(RW), 32'd0);
      chk("rst_mid_r3", 32'(rf[3]), 32'h10);
      run("ldi_post", 16'hA35A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      chk("rf_r3", 32'(rf[3]), 32'h5A);

      // Held instr_valid: each handshake is four edges after the previous one.
      @(negedge clk);
      chk("b2b_ready0", 32'(instr_ready), 32'd1);
      instr       = 16'hA111;
      instr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk($sformatf("b2b_busy_%0d_%0d", k, j), 32'(instr_ready), 32'd0);
            if (j == 1) begin
               if (k == 0) instr = 16'hA222;
               else if (k == 1) instr = 16'hA333;
               else instr_valid = 1'b0;
            end
         end
         @(negedge clk);
         chk($sformatf("b2b_ready_%0d", k), 32'(instr_ready), 32'd1);
      end
      chk("b2b_r1", 32'(rf[1]), 32'h11);
      chk("b2b_r2", 32'(rf[2]), 32'h22);
      chk("b2b_r3", 32'(rf[3]), 32'h33);
      chk_flags("b2b", 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
